// File: rtl/ula_wb_stage.sv
// Writeback stage behind the ALU: queues results with their N/Z/C/V flags and
// retires them to the register file; holds the architectural flag register.
module ula_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_setf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [3:0]        out_flags,
  output logic              rf_we,
  output logic [3:0]        flags
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic [3:0]        flags;
    logic              we;
    logic              setf;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push_c, pop_c;
  entry_t            head_c, wr_entry_c;
  logic [DATA_W-1:0] op2;
  logic              cin, arith, carry, ovf;
  logic [3:0]        flags_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;
  assign head_c = mem[rd_ptr];

  // Head fields read zero while the queue is empty.
  assign out_result = out_valid ? head_c.result : '0;
  assign out_rd     = out_valid ? head_c.rd     : '0;
  assign out_flags  = out_valid ? head_c.flags  : '0;
  assign rf_we      = pop_c & head_c.we;

  // Flags from the applied operands; the ALU result itself is trusted as given.
  always_comb begin
    op2   = '0;
    cin   = 1'b0;
    arith = 1'b0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (in_opcode)
      5'b00000: begin arith = 1'b1; op2 = in_b;                 end
      5'b00001: begin arith = 1'b1; op2 = in_b;  cin = 1'b1;    end
      5'b00011: begin arith = 1'b1; op2 = '0;    cin = 1'b1;    end
      5'b00101: begin arith = 1'b1; op2 = ~in_b; cin = 1'b1;    end
      5'b00100: begin arith = 1'b1; op2 = ~in_b;                end
      5'b00110: begin arith = 1'b1; op2 = '1;                   end
      5'b01000: carry = in_a[MSB];
      5'b01001: carry = in_a[0];
      default:  carry = 1'b0;
    endcase
    if (arith) begin
      carry = 1'((({1'b0, in_a} + {1'b0, op2} + SUM_W'(cin)) >> DATA_W));
      ovf   = (in_a[MSB] == op2[MSB]) && (in_result[MSB] != in_a[MSB]);
    end
    flags_c = {in_result[MSB], (in_result == '0), carry, ovf};
  end

  always_comb begin
    wr_entry_c        = '0;
    wr_entry_c.result = in_result;
    wr_entry_c.rd     = in_rd;
    wr_entry_c.flags  = flags_c;
    wr_entry_c.we     = in_we;
    wr_entry_c.setf   = in_setf;
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) count_nxt = count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt = count - CNT_W'(1);
  end

  // Entry storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_entry_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (head_c.setf) flags <= head_c.flags;
      end
      count     <= count_nxt;
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
      out_valid <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_ula_wb_stage.sv
// Bench for ula_wb_stage: queue/flag model checked every cycle plus directed literals.
module tb_ula_wb_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_we, in_setf;
  logic [31:0] in_a, in_b, in_result;
  logic [4:0]  in_opcode, in_rd;
  logic        out_valid, out_ready, rf_we;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [3:0]  out_flags, flags;

  int checks = 0;
  int passed = 0;

  ula_wb_stage #(.DATA_W(32), .RD_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_result(in_result),
    .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_flags(out_flags),
    .rf_we(rf_we), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Flags from arithmetic meaning: unsigned carry-out and signed range overflow.
  function automatic logic [3:0] model_flags(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] r);
    logic [31:0] e;
    longint unsigned us;
    longint ss;
    int ci;
    bit arith;
    logic c, v;
    e = 32'h0; ci = 0; arith = 1'b1; c = 1'b0; v = 1'b0;
    case (op)
      5'b00000: begin e = b;            ci = 0; end
      5'b00001: begin e = b;            ci = 1; end
      5'b00011: begin e = 32'h0;        ci = 1; end
      5'b00101: begin e = ~b;           ci = 1; end
      5'b00100: begin e = ~b;           ci = 0; end
      5'b00110: begin e = 32'hFFFFFFFF; ci = 0; end
      5'b01000: begin arith = 1'b0; c = a[31]; end
      5'b01001: begin arith = 1'b0; c = a[0];  end
      default:  arith = 1'b0;
    endcase
    if (arith) begin
      us = 64'(a) + 64'(e) + 64'(ci);
      c  = us[32];
      ss = longint'($signed(a)) + longint'($signed(e)) + longint'(ci);
      v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    return {r[31], (r == 32'h0), c, v};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic [3:0]  f;
    logic        we;
    logic        setf;
  } ent_t;

  ent_t        m_q[$];
  logic [3:0]  m_flags;
  logic        m_push, m_pop;

  // Reference queue: decide push from pre-edge occupancy, then pop, then push.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_flags = 4'b0000;
    end else begin
      m_push = in_valid && (m_q.size() != DEPTH);
      m_pop  = (m_q.size() != 0) && out_ready;
      if (m_pop) begin
        if (m_q[0].setf) m_flags = m_q[0].f;
        void'(m_q.pop_front());
      end
      if (m_push)
        m_q.push_back('{r: in_result, rd: in_rd, f: model_flags(in_opcode, in_a, in_b, in_result),
                        we: in_we, setf: in_setf});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, m_q.size() != 0);
      check("in_ready", in_ready, m_q.size() != DEPTH);
      check("flags", flags, m_flags);
      if (m_q.size() != 0) begin
        check("out_result", out_result, m_q[0].r);
        check("out_rd", out_rd, m_q[0].rd);
        check("out_flags", out_flags, m_q[0].f);
        check("rf_we", rf_we, out_ready && m_q[0].we);
      end else begin
        check("out_result_empty", out_result, 0);
        check("out_flags_empty", out_flags, 0);
        check("rf_we_empty", rf_we, 0);
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [4:0] rd, input logic we, input logic setf);
    in_opcode = op; in_a = a; in_b = b; in_result = r; in_rd = rd; in_we = we; in_setf = setf;
    in_valid = 1'b1;
  endtask

  // Entered just after a rising edge; returns just after the edge that took the push.
  task automatic push_wait(input string name);
    logic hs;
    int guard;
    guard = 0;
    do begin
      hs = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!hs && guard < 20);
    if (!hs) check({name, "_timeout"}, 0, 1);
    in_valid = 1'b0;
  endtask

  // Single entry through an empty stage with out_ready high.
  task automatic single(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] expf, input string name);
    out_ready = 1'b1;
    drive(op, a, b, r, 5'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_out_flags"}, out_flags, expf);
    @(posedge clk); #1;
    check({name, "_arch_flags"}, flags, expf);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(5'd0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags, 0);
    check("rst_out_result", out_result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Overflowing add
    out_ready = 1'b1;
    drive(5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("add_out_valid", out_valid, 1);
    check("add_out_flags", out_flags, 4'b1001);
    check("add_rf_we", rf_we, 1);
    check("add_out_rd", out_rd, 3);
    @(posedge clk); #1;
    check("add_flags", flags, 4'b1001);

    single(5'b00101, 32'd5, 32'd5, 32'h0, 4'b0110, "sub");
    single(5'b00100, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b1000, "subdec");
    single(5'b01000, 32'h80000001, 32'd0, 32'd2, 4'b0010, "lsl");
    single(5'b01001, 32'd1, 32'd0, 32'd0, 4'b0110, "asr");
    single(5'b01100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b1000, "xor");
    single(5'b00011, 32'hFFFFFFFF, 32'd0, 32'h0, 4'b0110, "inca");
    single(5'b00110, 32'h80000000, 32'd0, 32'h7FFFFFFF, 4'b0011, "deca");
    single(5'b00110, 32'h0, 32'd0, 32'hFFFFFFFF, 4'b1000, "deca0");
    single(5'b00001, 32'hFFFFFFFF, 32'd0, 32'h0, 4'b0110, "addinc");

    // Streaming push/pop at occupancy 1; setf=0 so flags hold
    out_ready = 1'b0;
    drive(5'b00000, 32'd100, 32'd1, 32'd101, 5'd1, 1'b1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(5'b00000, 32'(i), 32'(3 * i), 32'(4 * i), 5'(i), 1'(i % 2), 1'b0);
      @(posedge clk); #1;
      check("stream_out_valid", out_valid, 1);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_flags_held", flags, 4'b0110);

    // Backpressure: two fill the queue, the third is held
    out_ready = 1'b0;
    drive(5'b00000, 32'd10, 32'd20, 32'd30, 5'd10, 1'b1, 1'b1);
    push_wait("bp1");
    drive(5'b00000, 32'd11, 32'd21, 32'd32, 5'd11, 1'b1, 1'b1);
    push_wait("bp2");
    drive(5'b00000, 32'hFFFFFFFF, 32'd2, 32'd1, 5'd12, 1'b1, 1'b1);
    check("bp_full", in_ready, 0);
    @(posedge clk); #1;
    check("bp_still_full", in_ready, 0);
    check("bp_head_rd", out_rd, 10);
    out_ready = 1'b1;
    push_wait("bp3");
    repeat (3) begin @(posedge clk); #1; end
    check("bp_drained", out_valid, 0);
    check("bp_flags", flags, 4'b0010);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(5'b00000, 32'd1, 32'd1, 32'd2, 5'd20, 1'b1, 1'b1);
    push_wait("rst1");
    drive(5'b00101, 32'd1, 32'd2, 32'hFFFFFFFF, 5'd21, 1'b1, 1'b1);
    push_wait("rst2");
    check("rst_pre_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_flags", flags, 0);
    check("arst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_rf_we", rf_we, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_empty", out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
